// File: rtl/rf_dump_pkg.sv
// Shared definitions for the register-file dump reader: FSM encoding and address wrap helper.
package rf_dump_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_HALT = 3'd1;
    localparam logic [ST_W-1:0] ST_READ = 3'd2;
    localparam logic [ST_W-1:0] ST_SEND = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE = 3'd4;

    // Increment with wrap from depth-1 back to 0, so reversed ranges walk through the top.
    function automatic int unsigned next_addr(input int unsigned a, input int unsigned depth);
        return (a == depth - 1) ? 32'd0 : a + 32'd1;
    endfunction

endpackage

// File: rtl/rf_dump_reader.sv
// Halts the core, walks a register-file address range and streams each word out over valid/ready.
module rf_dump_reader
    import rf_dump_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_DEPTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic                  abort,
    output logic                  halt_req,
    input  logic                  halt_ack,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    logic [ST_W-1:0]       state_q,     state_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q,   rf_addr_d;
    logic [ADDR_WIDTH-1:0] last_q,      last_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic                  out_last_q,  out_last_d;
    logic                  halt_req_q,  halt_req_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  err_q,       err_d;
    logic                  range_bad;

    assign range_bad = (32'(first_addr) >= ADDR_DEPTH) || (32'(last_addr) >= ADDR_DEPTH);

    // Next-state and output-register logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d     = state_q;
        rf_addr_d   = rf_addr_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        last_d    = last_addr;
                        rf_addr_d = first_addr;
                        state_d   = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (halt_ack) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                out_data_d  = rf_data;
                out_addr_d  = rf_addr_q;
                out_valid_d = 1'b1;
                out_last_d  = (rf_addr_q == last_q);
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        rf_addr_d = ADDR_WIDTH'(next_addr(32'(rf_addr_q), ADDR_DEPTH));
                        state_d   = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pending word is withdrawn without a handshake when the dump is cancelled.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        halt_req_d = (state_d != ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rf_addr_q   <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            halt_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_addr_q   <= rf_addr_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            halt_req_q  <= halt_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign halt_req  = halt_req_q;
    assign rf_addr   = rf_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: table of dump ranges plus hand-written corner sequences.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, halt_ack, out_ready;
    logic [4:0]  first_addr, last_addr;
    logic        halt_req, out_valid, out_last, busy, done, err;
    logic [4:0]  rf_addr, out_addr;
    logic [31:0] rf_data, out_data;
    logic [31:0] regs [32];

    logic        start6, abort6, halt_ack6, out_ready6;
    logic [5:0]  first6, last6;
    logic        halt_req6, out_valid6, out_last6, busy6, done6, err6;
    logic [5:0]  rf_addr6, out_addr6;
    logic [31:0] rf_data6, out_data6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rf_data  = regs[rf_addr];
    assign rf_data6 = {26'd0, rf_addr6};

    rf_dump_reader #(.DATA_WIDTH(32), .ADDR_DEPTH(32), .ADDR_WIDTH(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .abort(abort), .halt_req(halt_req), .halt_ack(halt_ack), .rf_addr(rf_addr), .rf_data(rf_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    rf_dump_reader #(.DATA_WIDTH(32), .ADDR_DEPTH(32), .ADDR_WIDTH(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .first_addr(first6), .last_addr(last6),
        .abort(abort6), .halt_req(halt_req6), .halt_ack(halt_ack6), .rf_addr(rf_addr6), .rf_data(rf_data6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6), .out_addr(out_addr6),
        .out_last(out_last6), .busy(busy6), .done(done6), .err(err6)
    );

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        int         ack_dly;
        int         n_words;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        start = 1'b1; first_addr = f; last_addr = l;
        tick();
        start = 1'b0;
    endtask

    task automatic ack(input int dly);
        repeat (dly) tick();
        halt_ack = 1'b1;
        tick();
        halt_ack = 1'b0;
    endtask

    // Entered in the READ cycle; checks every accepted word against the expected address walk.
    task automatic drain(input logic [4:0] f, input int n_exp, input string tag);
        int         n = 0;
        int         words = 0;
        int         dones = 0;
        logic [4:0] ea = f;
        while (busy && n < 200) begin
            if (out_valid && out_ready) begin
                chk({tag, " addr"}, 32'(out_addr), 32'(ea));
                chk({tag, " data"}, out_data, 32'h100 + 32'(ea));
                chk({tag, " last"}, 32'(out_last), 32'(words == n_exp - 1));
                words++;
                ea = 5'(ea + 5'd1);
            end
            if (done) dones++;
            tick();
            n++;
        end
        chk({tag, " words"}, 32'(words), 32'(n_exp));
        chk({tag, " done_pulses"}, 32'(dones), 32'd1);
        chk({tag, " cycles"}, 32'(n), 32'(2 * n_exp + 1));
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        chk({tag, " halt_end"}, 32'(halt_req), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [5];
        int   cnt;
        int   n;
        vecs[0] = '{5'd0,  5'd31, 2, 32};
        vecs[1] = '{5'd30, 5'd1,  2, 4};
        vecs[2] = '{5'd7,  5'd7,  0, 1};
        vecs[3] = '{5'd10, 5'd12, 3, 3};
        vecs[4] = '{5'd31, 5'd0,  1, 2};

        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; halt_ack = 1'b0; out_ready = 1'b1;
        first_addr = '0; last_addr = '0;
        start6 = 1'b0; abort6 = 1'b0; halt_ack6 = 1'b0; out_ready6 = 1'b1; first6 = '0; last6 = '0;
        @(negedge clk);
        chk("rst halt_req", 32'(halt_req), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst rf_addr", 32'(rf_addr), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst busy_done_err", {29'd0, busy, done, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            start_dump(vecs[i].first, vecs[i].last);
            chk($sformatf("v%0d halt_req", i), 32'(halt_req), 32'd1);
            chk($sformatf("v%0d rf_addr", i), 32'(rf_addr), 32'(vecs[i].first));
            ack(vecs[i].ack_dly);
            drain(vecs[i].first, vecs[i].n_words, $sformatf("v%0d", i));
            tick();
        end

        // Backpressure: single word held for 7 stalled cycles
        regs[5] = 32'hDEADBEEF;
        out_ready = 1'b0;
        start_dump(5'd5, 5'd5);
        ack(0);
        tick();
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("bp valid c%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp data c%0d", c), out_data, 32'hDEADBEEF);
            chk($sformatf("bp last c%0d", c), 32'(out_last), 32'd1);
            chk($sformatf("bp addr c%0d", c), 32'(out_addr), 32'd5);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp valid_after", 32'(out_valid), 32'd0);
        chk("bp done", 32'(done), 32'd1);
        tick();
        chk("bp busy_end", 32'(busy), 32'd0);
        chk("bp done_end", 32'(done), 32'd0);
        regs[5] = 32'h105;

        // start during a dump is ignored
        start_dump(5'd0, 5'd3);
        start = 1'b1; first_addr = 5'd20; last_addr = 5'd20;
        tick();
        start = 1'b0;
        chk("ign err", 32'(err), 32'd0);
        chk("ign busy", 32'(busy), 32'd1);
        ack(1);
        drain(5'd0, 4, "ign");

        // start and abort together in IDLE: start wins
        start = 1'b1; abort = 1'b1; first_addr = 5'd9; last_addr = 5'd9;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa busy", 32'(busy), 32'd1);
        chk("sa halt_req", 32'(halt_req), 32'd1);
        ack(0);
        drain(5'd9, 1, "sa");

        // Abort on the third word while the sink stalls
        start_dump(5'd10, 5'd20);
        ack(0);
        cnt = 0; n = 0;
        while (cnt < 2 && n < 50) begin
            if (out_valid && out_ready) cnt++;
            tick();
            n++;
        end
        out_ready = 1'b0;
        tick();
        chk("ab valid_w3", 32'(out_valid), 32'd1);
        chk("ab addr_w3", 32'(out_addr), 32'd12);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab valid", 32'(out_valid), 32'd0);
        chk("ab halt_req", 32'(halt_req), 32'd0);
        chk("ab busy", 32'(busy), 32'd0);
        chk("ab last", 32'(out_last), 32'd0);
        chk("ab done", 32'(done), 32'd0);
        tick();
        chk("ab done_late", 32'(done), 32'd0);
        out_ready = 1'b1;
        start_dump(5'd3, 5'd4);
        ack(0);
        drain(5'd3, 2, "ab_restart");

        // Asynchronous reset while waiting for halt_ack
        start_dump(5'd6, 5'd8);
        chk("rh halt_req_pre", 32'(halt_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rh halt_req", 32'(halt_req), 32'd0);
        chk("rh busy", 32'(busy), 32'd0);
        chk("rh rf_addr", 32'(rf_addr), 32'd0);
        chk("rh out_data", out_data, 32'd0);
        chk("rh out_addr", 32'(out_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Out-of-range rejection on the 6-bit address build
        start6 = 1'b1; first6 = 6'd40; last6 = 6'd2;
        tick();
        start6 = 1'b0;
        chk("rj err_first", 32'(err6), 32'd1);
        chk("rj busy_first", 32'(busy6), 32'd0);
        tick();
        chk("rj err_pulse", 32'(err6), 32'd0);
        start6 = 1'b1; first6 = 6'd3; last6 = 6'd33;
        tick();
        start6 = 1'b0;
        chk("rj err_last", 32'(err6), 32'd1);
        chk("rj halt_last", 32'(halt_req6), 32'd0);
        tick();
        start6 = 1'b1; first6 = 6'd31; last6 = 6'd31;
        tick();
        start6 = 1'b0;
        chk("rj ok_err", 32'(err6), 32'd0);
        chk("rj ok_busy", 32'(busy6), 32'd1);
        abort6 = 1'b1;
        tick();
        abort6 = 1'b0;
        chk("rj abort_busy", 32'(busy6), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
